ppi_bus_master: RTL and testbench



---
 rtl/ppi_pkg.sv | 24 ++
 rtl/ppi_phase_timer.sv | 26 ++
 rtl/ppi_bus_master.sv | 144 ++++++++++++++
 tb/tb_ppi_bus_master.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ppi_pkg.sv
// Shared types and constants for the PPI8255A CPU-side bus master.
package ppi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } ppiState_t;

  localparam logic [1:0] PPI_PORTA = 2'b00;
  localparam logic [1:0] PPI_PORTB = 2'b01;
  localparam logic [1:0] PPI_PORTC = 2'b10;
  localparam logic [1:0] PPI_CTRL  = 2'b11;

  // All ports input, mode 0
  localparam logic [7:0] PPI_DEFAULT_CW = 8'h9B;

  // Phase timer load value; a cycle count of 0 behaves as 1
  function automatic logic [3:0] phaseLoad(input int unsigned cyc);
    return (cyc == 0) ? 4'd0 : 4'(cyc - 1);
  endfunction

endpackage

// File: rtl/ppi_phase_timer.sv
// 4-bit loadable down-counter; zero flags the last cycle of a phase.
import ppi_pkg::*;

module ppi_phase_timer (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       load,
  input  logic [3:0] loadVal,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= loadVal;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/ppi_bus_master.sv
// PPI8255A bus-cycle sequencer: valid/ready requests to phased nCs/nRe/nWr/A strobes.
// Define PPI_INIT_EN to issue one INIT_CW write to the control register after reset.
//
// state  | meaning
// IDLE   | ready for a request, bus released
// SETUP  | nCs/A (and write data) valid ahead of the strobe
// STROBE | nRe or nWr low
// HOLD   | strobe released, nCs/A/data still held
import ppi_pkg::*;

module ppi_bus_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 3,
  parameter int unsigned HOLD_CYC   = 1,
  parameter logic [7:0]  INIT_CW    = PPI_DEFAULT_CW
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       ReqValid,
  output logic       ReqReady,
  input  logic       ReqWr,
  input  logic [1:0] ReqAddr,
  input  logic [7:0] ReqData,
  output logic       RspValid,
  output logic [7:0] RspData,
  output logic       nCs,
  output logic       nRe,
  output logic       nWr,
  output logic [1:0] A,
  output logic [7:0] DOut,
  output logic       DOe,
  input  logic [7:0] DIn,
  output logic       Busy
);

  localparam logic [3:0] SETUP_LD  = phaseLoad(SETUP_CYC);
  localparam logic [3:0] STROBE_LD = phaseLoad(STROBE_CYC);
  localparam logic [3:0] HOLD_LD   = phaseLoad(HOLD_CYC);

`ifdef PPI_INIT_EN
  localparam logic READY_RST = 1'b0;
`else
  localparam logic READY_RST = 1'b1;
`endif

  ppiState_t  state;
  logic       isWr;
  logic       initPending;
  logic       start;
  logic       startWr;
  logic [1:0] startAddr;
  logic [7:0] startData;
  logic       timerLoad;
  logic [3:0] timerVal;
  logic       timerZero;

`ifdef PPI_INIT_EN
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      initPending <= 1'b1;
    end else if (state == IDLE) begin
      initPending <= 1'b0;
    end
  end
`else
  assign initPending = 1'b0;
`endif

  // ReqReady is low while the init write is pending, so the two never collide
  assign start     = (state == IDLE) && ((ReqValid && ReqReady) || initPending);
  assign startWr   = initPending ? 1'b1    : ReqWr;
  assign startAddr = initPending ? PPI_CTRL : ReqAddr;
  assign startData = initPending ? INIT_CW  : ReqData;
  assign Busy      = (state != IDLE);

  always_comb begin
    timerLoad = 1'b0;
    timerVal  = 4'd0;
    case (state)
      IDLE:    begin timerLoad = start;     timerVal = SETUP_LD;  end
      SETUP:   begin timerLoad = timerZero; timerVal = STROBE_LD; end
      STROBE:  begin timerLoad = timerZero; timerVal = HOLD_LD;   end
      HOLD:    begin timerLoad = timerZero; timerVal = 4'd0;      end
      default: begin timerLoad = 1'b0;      timerVal = 4'd0;      end
    endcase
  end

  ppi_phase_timer uTimer (
    .Clk     (Clk),
    .nReset  (nReset),
    .load    (timerLoad),
    .loadVal (timerVal),
    .zero    (timerZero)
  );

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      isWr     <= 1'b0;
      ReqReady <= READY_RST;
      nCs      <= 1'b1;
      nRe      <= 1'b1;
      nWr      <= 1'b1;
      A        <= 2'b00;
      DOut     <= 8'h00;
      DOe      <= 1'b0;
      RspValid <= 1'b0;
      RspData  <= 8'h00;
    end else begin
      RspValid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= SETUP;
          ReqReady <= 1'b0;
          isWr     <= startWr;
          A        <= startAddr;
          DOut     <= startWr ? startData : 8'h00;
          DOe      <= startWr;
          nCs      <= 1'b0;
        end
        SETUP: if (timerZero) begin
          state <= STROBE;
          nWr   <= ~isWr;
          nRe   <= isWr;
        end
        STROBE: if (timerZero) begin
          state <= HOLD;
          nWr   <= 1'b1;
          nRe   <= 1'b1;
          if (!isWr) RspData <= DIn;
        end
        HOLD: if (timerZero) begin
          state    <= IDLE;
          nCs      <= 1'b1;
          DOe      <= 1'b0;
          ReqReady <= 1'b1;
          RspValid <= ~isWr;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppi_bus_master.sv
// Self-checking bench for ppi_bus_master: per-cycle strobe checks plus a read-data scoreboard.
module tb_ppi_bus_master;
  import ppi_pkg::*;

`ifdef PPI_INIT_EN
  localparam logic RST_RDY = 1'b0;
`else
  localparam logic RST_RDY = 1'b1;
`endif

  // Effective phase lengths: default instance and the all-zero (clamped) instance
  localparam int SD = 1, TD = 3, HD = 1;
  localparam int SZ = 1, TZ = 1, HZ = 1;

  logic Clk = 1'b0;
  logic nReset = 1'b0;
  always #5 Clk = ~Clk;

  logic       reqValid, reqWr, sel;
  logic [1:0] reqAddr;
  logic [7:0] reqData, dIn;

  logic       rdyD, rspVD, nCsD, nReD, nWrD, doeD, busyD;
  logic [1:0] aD;
  logic [7:0] rspDD, dOutD;
  logic       rdyZ, rspVZ, nCsZ, nReZ, nWrZ, doeZ, busyZ;
  logic [1:0] aZ;
  logic [7:0] rspDZ, dOutZ;

  int nChecks = 0;
  int nFails  = 0;
  logic [7:0] sbQ[$];

  ppi_bus_master dutD (
    .Clk(Clk), .nReset(nReset), .ReqValid(reqValid & ~sel), .ReqReady(rdyD),
    .ReqWr(reqWr), .ReqAddr(reqAddr), .ReqData(reqData),
    .RspValid(rspVD), .RspData(rspDD), .nCs(nCsD), .nRe(nReD), .nWr(nWrD),
    .A(aD), .DOut(dOutD), .DOe(doeD), .DIn(dIn), .Busy(busyD)
  );

  ppi_bus_master #(.SETUP_CYC(0), .STROBE_CYC(0), .HOLD_CYC(0)) dutZ (
    .Clk(Clk), .nReset(nReset), .ReqValid(reqValid & sel), .ReqReady(rdyZ),
    .ReqWr(reqWr), .ReqAddr(reqAddr), .ReqData(reqData),
    .RspValid(rspVZ), .RspData(rspDZ), .nCs(nCsZ), .nRe(nReZ), .nWr(nWrZ),
    .A(aZ), .DOut(dOutZ), .DOe(doeZ), .DIn(dIn), .Busy(busyZ)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nChecks++;
    if (obs !== expv) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Full bus/handshake vector in cycle c of a transaction of n cycles
  task automatic checkCycle(input string tag, input int c, input int s, input int t, input int n,
                            input logic wr, input logic [1:0] addr, input logic [7:0] data);
    logic inTxn, strb;
    logic oCs, oRe, oWr, oDoe, oRspV, oBusy, oRdy;
    logic [1:0] oA;
    logic [7:0] oD;
    logic [16:0] expV, obsV;
    inTxn = (c >= 1) && (c <= n);
    strb  = (c > s) && (c <= s + t);
    oCs = sel ? nCsZ : nCsD;   oRe = sel ? nReZ : nReD;     oWr = sel ? nWrZ : nWrD;
    oDoe = sel ? doeZ : doeD;  oRspV = sel ? rspVZ : rspVD; oBusy = sel ? busyZ : busyD;
    oRdy = sel ? rdyZ : rdyD;  oA = sel ? aZ : aD;          oD = sel ? dOutZ : dOutD;
    expV = {~inTxn, ~(strb & ~wr), ~(strb & wr), inTxn & wr, (c == n + 1) & ~wr, inTxn, ~inTxn,
            inTxn ? addr : 2'b00, (inTxn & wr) ? data : 8'h00};
    obsV = {oCs, oRe, oWr, oDoe, oRspV, oBusy, oRdy,
            inTxn ? oA : 2'b00, (inTxn & wr) ? oD : 8'h00};
    checkVal($sformatf("%s c%0d", tag, c), 32'(obsV), 32'(expV));
  endtask

  task automatic checkReset(input string tag);
    checkVal(tag,
      32'({nCsD, nReD, nWrD, doeD, rspVD, busyD, rdyD, aD, dOutD, rspDD}),
      32'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, RST_RDY, 2'b00, 8'h00, 8'h00}));
  endtask

  // Drive a request, wait for accept (bounded), then check every cycle through the first IDLE cycle
  task automatic txn(input string tag, input logic wr, input logic [1:0] addr,
                     input logic [7:0] data, input logic [7:0] din, input logic keep);
    int s, t, n, budget;
    s = sel ? SZ : SD;
    t = sel ? TZ : TD;
    n = s + t + (sel ? HZ : HD);
    reqWr = wr; reqAddr = addr; reqData = data; dIn = din; reqValid = 1'b1;
    if (!wr) sbQ.push_back(din);
    budget = 0;
    while (!(sel ? rdyZ : rdyD) && budget < 50) begin
      @(negedge Clk);
      budget++;
    end
    if (budget >= 50) begin
      checkVal({tag, " accept timeout"}, 32'd0, 32'd1);
      reqValid = 1'b0;
      if (!wr) void'(sbQ.pop_back());
      return;
    end
    @(posedge Clk);
    #1;
    if (!keep) reqValid = 1'b0;
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge Clk);
      checkCycle(tag, c, s, t, n, wr, addr, data);
    end
  endtask

  always @(negedge Clk) begin
    if (nReset) begin
      checkVal("invariant", 32'({~nReD & doeD, ~nReD & ~nWrD, ~nReZ & doeZ, ~nReZ & ~nWrZ}), 32'd0);
      if (rspVD || rspVZ) begin
        if (sbQ.size() == 0) checkVal("rsp unexpected", 32'd1, 32'd0);
        else checkVal("rspData", 32'(rspVZ ? rspDZ : rspDD), 32'(sbQ.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int budget;
    reqValid = 1'b0; reqWr = 1'b0; reqAddr = 2'b00; reqData = 8'h00; dIn = 8'h00; sel = 1'b0;
    repeat (3) @(negedge Clk);
    checkReset("reset state");
    nReset = 1'b1;
`ifdef PPI_INIT_EN
    @(posedge Clk);
    for (int c = 1; c <= SD + TD + HD + 1; c++) begin
      @(negedge Clk);
      checkCycle("init", c, SD, TD, SD + TD + HD, 1'b1, PPI_CTRL, PPI_DEFAULT_CW);
    end
`else
    @(negedge Clk);
    checkVal("ready after reset", 32'(rdyD), 32'd1);
`endif

    txn("wr ctrl 80", 1'b1, PPI_CTRL, 8'h80, 8'h00, 1'b0);
    repeat (2) @(negedge Clk);
    txn("rd portA A5", 1'b0, PPI_PORTA, 8'h00, 8'hA5, 1'b0);
    txn("rd portB 3C", 1'b0, PPI_PORTB, 8'h00, 8'h3C, 1'b0);
    txn("wr portC 5A", 1'b1, PPI_PORTC, 8'h5A, 8'h00, 1'b0);

    txn("b2b wr portB 11", 1'b1, PPI_PORTB, 8'h11, 8'h00, 1'b1);
    txn("b2b rd portC C3", 1'b0, PPI_PORTC, 8'h00, 8'hC3, 1'b0);
    txn("wr portA 00", 1'b1, PPI_PORTA, 8'h00, 8'h00, 1'b0);
    checkVal("rspData hold", 32'(rspDD), 32'h0000_00C3);

    @(negedge Clk);
    sel = 1'b1;
    repeat (2) @(negedge Clk);
    txn("zero rd portA 96", 1'b0, PPI_PORTA, 8'h00, 8'h96, 1'b0);
    txn("zero wr ctrl 4D", 1'b1, PPI_CTRL, 8'h4D, 8'h00, 1'b0);
    @(negedge Clk);
    sel = 1'b0;
    @(negedge Clk);

    // Reset in cycle 3 of a read, while nRe is low
    reqWr = 1'b0; reqAddr = PPI_PORTB; reqData = 8'h00; dIn = 8'hE7; reqValid = 1'b1;
    sbQ.push_back(8'hE7);
    budget = 0;
    while (!rdyD && budget < 50) begin
      @(negedge Clk);
      budget++;
    end
    checkVal("abort accept", 32'(rdyD), 32'd1);
    @(posedge Clk);
    #1 reqValid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge Clk);
      checkCycle("abort rd", c, SD, TD, SD + TD + HD, 1'b0, PPI_PORTB, 8'h00);
    end
    @(posedge Clk);
    #2 nReset = 1'b0;
    #1 checkReset("abort reset");
    void'(sbQ.pop_back());
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
    repeat (2) @(negedge Clk);
    txn("post-abort rd portA 69", 1'b0, PPI_PORTA, 8'h00, 8'h69, 1'b0);
    txn("wr portB FF", 1'b1, PPI_PORTB, 8'hFF, 8'h00, 1'b0);
    checkVal("rspData post-abort", 32'(rspDD), 32'h0000_0069);
    repeat (3) @(negedge Clk);
    checkVal("scoreboard empty", 32'(sbQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
